// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: UART receive byte buffer with circular FIFO.
// Acks every byte on the four-phase handshake and drops it when the FIFO is full.
// Ports:
//   inclk, rst       clock, async active-high reset
//   rx_data, rx_rdy  byte and request from the UART core
//   rx_ack           four-phase acknowledge back to the UART core
//   rd_en            consumer pop request (ignored when empty)
//   rd_data          popped byte, registered
//   rd_valid         one-cycle pulse when rd_data is updated
//   empty, full      occupancy flags
//   afull            level >= AFULL_LVL
//   level            current occupancy
//   ovf, ovf_clr     sticky drop flag and its clear
// Option UART_RXBUF_STATS_EN adds these outputs:
//   byte_cnt  bytes written, wraps
//   drop_cnt  bytes dropped, saturates
module uart_rx_buffer #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int AFULL_LVL  = 12
) (
  input  logic              inclk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_rdy,
  output logic              rx_ack,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic              afull,
  output logic [DEPTH_LOG2:0] level,
  output logic              ovf,
`ifdef UART_RXBUF_STATS_EN
  output logic [15:0]       byte_cnt,
  output logic [7:0]        drop_cnt,
`endif
  input  logic              ovf_clr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] AFULL_V =
    PW'(AFULL_LVL);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t state, state_n;
  logic   ack_n;
  logic   wr_req;
  logic   drop;
  logic   rd_fire;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic [DATA_W-1:0] mem [DEPTH];

  // Occupancy and flags come straight from
  // the registered pointers.
  assign level = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  =
    (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
    (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
  assign afull = (level >= AFULL_V);

  assign rd_fire = rd_en & ~empty;

  // Capture FSM: state register
  always_ff @(posedge inclk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rx_ack <= 1'b0;
    end else begin
      state  <= state_n;
      rx_ack <= ack_n;
    end
  end

  // Capture FSM: next state. A byte is taken
  // once per rx_rdy episode; full drops it
  // but still acks so the UART never stalls.
  always_comb begin
    state_n = state;
    ack_n   = rx_ack;
    wr_req  = 1'b0;
    drop    = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_rdy) begin
          ack_n   = 1'b1;
          state_n = HOLD;
          if (full) begin
            drop = 1'b1;
          end else begin
            wr_req = 1'b1;
          end
        end
      end
      HOLD: begin
        if (!rx_rdy) begin
          ack_n   = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        ack_n   = 1'b0;
      end
    endcase
  end

  // Storage is not reset.
  always_ff @(posedge inclk) begin
    if (wr_req) begin
      mem[wr_ptr[PW-2:0]] <= rx_data;
    end
  end

  always_ff @(posedge inclk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
    end else if (wr_req) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge inclk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
    end else if (rd_fire) begin
      rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Registered read port; rd_data holds
  // between pops.
  always_ff @(posedge inclk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      if (rd_fire) begin
        rd_data <= mem[rd_ptr[PW-2:0]];
      end
    end
  end

  // A drop in the same cycle as ovf_clr
  // keeps the flag set.
  always_ff @(posedge inclk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

`ifdef UART_RXBUF_STATS_EN
  always_ff @(posedge inclk or posedge rst) begin
    if (rst) begin
      byte_cnt <= '0;
    end else if (wr_req) begin
      byte_cnt <= byte_cnt + 16'd1;
    end
  end

  always_ff @(posedge inclk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule
